iomem_ram_ctrl: RTL and testbench
=================================

Name: iomem_ram_ctrl

Overview:
- Parametrised RAM-window controller on the core's iomem bus; replaces the fixed 16-stage ready shift register used for main memory.
- Decodes a base/mask address window and emulates programmable, separate read and write latencies with a down-counter FSM.
- Issues exactly one ready pulse per transaction, commits each write exactly once, and aborts cleanly if the request is withdrawn.
- Exposes completion and abort counters for debug and ILA.

Parameters:
- BASE_ADDR, 32'h4000_0000, window base address.
- MASK_ADDR, 32'h000f_ffff, window mask; hit = (addr & ~MASK_ADDR) == BASE_ADDR.
- RD_LAT, 16, cycles from accept to ready for reads; legal range 1..255.
- WR_LAT, 16, cycles from accept to ready for writes; legal range 1..255.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_wiz_o  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- iomem_valid  in  1  core request valid.
- iomem_wstrb  in  4  byte strobes; 0 = read.
- iomem_addr  in  32  request address.
- sel_o  out  1  combinational window hit (valid & address match).
- ready_o  out  1  one-cycle completion pulse to the iomem ready mux.
- mem_rd_en_o  out  1  RAM read enable.
- mem_wstrb_o  out  4  RAM byte write strobes.
- busy_o  out  1  FSM not in IDLE.
- rd_cnt_o  out  CNT_W  completed reads.
- wr_cnt_o  out  CNT_W  completed writes.
- abort_cnt_o  out  CNT_W  aborted transactions.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE.
  - ready_o, mem_rd_en_o, busy_o = 0; mem_wstrb_o = 0.
  - All counters = 0; internal latency counter and latches = 0.
- Reset applied mid-transaction drops the transaction silently: no ready, no write, no abort count.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On sel_o, latch is_wr = |iomem_wstrb, the strobes and the address.
  - Load the latency counter with (is_wr ? WR_LAT : RD_LAT) - 1.
  - If the loaded value is 0, go to RESP; otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 0.
  - Abort to IDLE if, in any WAIT cycle, iomem_valid = 0, the address differs from the latched address, or the strobes differ from the latched strobes.
  - An abort increments abort_cnt_o and produces no ready and no write.
- RESP:
  - ready_o = 1 for exactly this cycle.
  - For writes, mem_wstrb_o = latched strobes for this cycle only.
  - Increment rd_cnt_o or wr_cnt_o, then go to IDLE unconditionally.
  - No abort check in RESP.
- Latency: a request accepted at cycle T sees ready_o high at cycle T+LAT, measured from the accept edge.
  - RD_LAT = 1 gives ready on the cycle after accept.
- mem_rd_en_o is high from the accept cycle through RESP for reads, so RAM output data is stable while ready_o is high. It is low for writes.
- Back-to-back requests: IDLE accepts a new request in the cycle after RESP. There is no dead cycle beyond that.
- Out-of-window requests: sel_o = 0 and the FSM stays in IDLE.
- Counters wrap modulo 2^CNT_W.
- busy_o = (state != IDLE).

Decomposition:
- Shared package iomem_pkg holds:
  - The FSM state enum: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - RAM_BASE_ADDR and RAM_MASK_ADDR constants.
  - The timer addresses 32'h3000_0000 and 32'h3000_0004, for reuse by the top level and peripherals.
- One natural sub-module, iomem_stat_cnt: a CNT_W-bit increment-enable wrap counter, instantiated three times.

Test Plan:
- Read at 32'h4000_0010 with RD_LAT = 16, valid held -> ready_o exactly at accept+16 for 1 cycle; mem_rd_en_o high for 17 cycles; rd_cnt_o = 1.
- Write of 32'hDEADBEEF, wstrb 4'b0011, WR_LAT = 4 -> mem_wstrb_o = 4'b0011 for exactly 1 cycle coincident with ready_o at accept+4; wr_cnt_o = 1; RAM word low half updated once.
- Read with valid dropped at accept+5 (RD_LAT = 16) -> no ready_o; FSM in IDLE at accept+6; abort_cnt_o = 1; rd_cnt_o unchanged.
- Access to 32'h3000_0000 and 32'h2000_0000 -> sel_o = 0, busy_o = 0, no ready, counters unchanged.
- Back-to-back reads, RD_LAT = 1, new request the cycle after ready -> ready_o every 2 cycles; rd_cnt_o = 3 after 3 requests.
- rst_n low during WAIT of a write -> no ready or write strobe; all outputs 0 on the next cycle; counters 0; next request behaves normally.

Source files
------------

// File: rtl/iomem_pkg.sv
// iomem_pkg
// Shared definitions for the iomem bus slaves.
//   - FSM state encoding for the RAM window controller (IDLE/WAIT/RESP)
//   - RAM window base/mask defaults
//   - Timer peripheral register addresses, shared with the top level
//   - addr_hit(): base/mask window decode helper
package iomem_pkg;

  // FSM state type and its legacy-compatible encodings
  typedef logic [1:0] iomem_state_t;

  localparam iomem_state_t IDLE = 2'd0;
  localparam iomem_state_t WAIT = 2'd1;
  localparam iomem_state_t RESP = 2'd2;

  // Main memory window: 1 MiB at 0x4000_0000
  localparam logic [31:0] RAM_BASE_ADDR = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK_ADDR = 32'h000f_ffff;

  // Timer peripheral registers
  localparam logic [31:0] TIMER_ADDR     = 32'h3000_0000;
  localparam logic [31:0] TIMER_CMP_ADDR = 32'h3000_0004;

  // An address hits a window when every bit outside the mask equals the base
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & ~mask) == base;
  endfunction

endpackage

// File: rtl/iomem_stat_cnt.sv
// iomem_stat_cnt
// Increment-enable statistics counter that wraps modulo 2^CNT_W.
// Ports:
//   clk_wiz_o  in   system clock
//   rst_n      in   synchronous active-low reset, clears the count
//   inc        in   add one to the count on this clock edge
//   count      out  current count
module iomem_stat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_wiz_o,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Wrap-around is the natural overflow of the adder
  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/iomem_ram_ctrl.sv
// iomem_ram_ctrl
// RAM window controller on the core's iomem bus. Decodes a base/mask window,
// emulates separate programmable read/write latencies with a down-counter
// FSM, produces exactly one ready pulse per transaction, commits each write
// exactly once and aborts if the request is withdrawn or changed while
// waiting. Completion/abort counters are exposed for debug.
// Ports:
//   clk_wiz_o    in   system clock
//   rst_n        in   synchronous active-low reset
//   iomem_valid  in   core request valid
//   iomem_wstrb  in   byte strobes, 0 = read
//   iomem_addr   in   request address
//   sel_o        out  combinational window hit (valid & address match)
//   ready_o      out  one-cycle completion pulse
//   mem_rd_en_o  out  RAM read enable (accept cycle through RESP, reads only)
//   mem_wstrb_o  out  RAM byte write strobes, driven in RESP of writes only
//   busy_o       out  FSM not in IDLE
//   rd_cnt_o     out  completed reads
//   wr_cnt_o     out  completed writes
//   abort_cnt_o  out  aborted transactions
// RD_LAT and WR_LAT must lie in 1..255.
module iomem_ram_ctrl
  import iomem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = RAM_BASE_ADDR,
  parameter logic [31:0] MASK_ADDR = RAM_MASK_ADDR,
  parameter int          RD_LAT    = 16,
  parameter int          WR_LAT    = 16,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_wiz_o,
  input  logic             rst_n,
  input  logic             iomem_valid,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  output logic             sel_o,
  output logic             ready_o,
  output logic             mem_rd_en_o,
  output logic [3:0]       mem_wstrb_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic [CNT_W-1:0] abort_cnt_o
);

  // Counter preload is latency-1: the accept edge itself counts as one cycle
  localparam logic [7:0] RD_LOAD = 8'(RD_LAT - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_LAT - 1);

  iomem_state_t state_q;
  iomem_state_t state_d;
  logic [7:0]   lat_cnt_q;
  logic [7:0]   lat_cnt_d;
  logic         is_wr_q;
  logic [3:0]   wstrb_q;
  logic [31:0]  addr_q;

  logic         req_is_wr;
  logic         req_changed;
  logic         accept;
  logic [7:0]   load_val;
  logic [7:0]   lat_dec;
  logic         rd_done;
  logic         wr_done;
  logic         abort;

  assign req_is_wr = |iomem_wstrb;
  assign sel_o     = iomem_valid & addr_hit(iomem_addr, BASE_ADDR, MASK_ADDR);
  assign load_val  = req_is_wr ? WR_LOAD : RD_LOAD;
  assign lat_dec   = lat_cnt_q - 8'd1;

  // The request must stay identical while waiting, otherwise the core has
  // moved on and completing it would ack or write the wrong access
  assign req_changed = !iomem_valid
                     || (iomem_addr  != addr_q)
                     || (iomem_wstrb != wstrb_q);

  // Next-state logic; abort takes priority over reaching RESP
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    accept    = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_o) begin
          accept    = 1'b1;
          lat_cnt_d = load_val;
          state_d   = (load_val == 8'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (req_changed) begin
          abort     = 1'b1;
          lat_cnt_d = 8'd0;
          state_d   = IDLE;
        end else begin
          lat_cnt_d = lat_dec;
          if (lat_dec == 8'd0) begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        rd_done = !is_wr_q;
        wr_done = is_wr_q;
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = 8'd0;
      end
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lat_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // Request latches, captured only on accept
  always_ff @(posedge clk_wiz_o) begin
    if (!rst_n) begin
      is_wr_q <= 1'b0;
      wstrb_q <= 4'd0;
      addr_q  <= 32'd0;
    end else if (accept) begin
      is_wr_q <= req_is_wr;
      wstrb_q <= iomem_wstrb;
      addr_q  <= iomem_addr;
    end
  end

  // Read enable starts combinationally in the accept cycle so RAM data has
  // settled long before ready; gated by rst_n so reset holds it low
  assign mem_rd_en_o = (state_q == IDLE) ? (rst_n & sel_o & ~req_is_wr)
                                         : ~is_wr_q;
  assign ready_o     = (state_q == RESP);
  assign mem_wstrb_o = ((state_q == RESP) && is_wr_q) ? wstrb_q : 4'd0;
  assign busy_o      = (state_q != IDLE);

  iomem_stat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk_wiz_o (clk_wiz_o),
    .rst_n     (rst_n),
    .inc       (rd_done),
    .count     (rd_cnt_o)
  );

  iomem_stat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk_wiz_o (clk_wiz_o),
    .rst_n     (rst_n),
    .inc       (wr_done),
    .count     (wr_cnt_o)
  );

  iomem_stat_cnt #(.CNT_W(CNT_W)) u_abort_cnt (
    .clk_wiz_o (clk_wiz_o),
    .rst_n     (rst_n),
    .inc       (abort),
    .count     (abort_cnt_o)
  );

endmodule

// File: tb/tb_iomem_ram_ctrl.sv
// tb_iomem_ram_ctrl
// Directed bench for iomem_ram_ctrl. Instance dut uses RD_LAT=16/WR_LAT=4,
// instance dut_f uses RD_LAT=1/WR_LAT=1 for back-to-back traffic. A small
// behavioural RAM commits writes from dut's mem_wstrb_o.
module tb_iomem_ram_ctrl;

  logic        clk_wiz_o = 1'b0;
  logic        rst_n;
  logic        iomem_valid;
  logic        valid_f;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] wdata;

  logic        sel_o, ready_o, mem_rd_en_o, busy_o;
  logic [3:0]  mem_wstrb_o;
  logic [15:0] rd_cnt_o, wr_cnt_o, abort_cnt_o;

  logic        f_sel, f_ready, f_rd_en, f_busy;
  logic [3:0]  f_wstrb;
  logic [15:0] f_rd_cnt, f_wr_cnt, f_abort_cnt;

  int checks = 0;
  int errors = 0;
  int exp_abort = 0;

  logic [31:0] ram [0:15] = '{default: 32'h0};
  int          write_events = 0;

  always #5 clk_wiz_o = ~clk_wiz_o;

  iomem_ram_ctrl #(.RD_LAT(16), .WR_LAT(4)) dut (
    .clk_wiz_o   (clk_wiz_o),
    .rst_n       (rst_n),
    .iomem_valid (iomem_valid),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .sel_o       (sel_o),
    .ready_o     (ready_o),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_wstrb_o (mem_wstrb_o),
    .busy_o      (busy_o),
    .rd_cnt_o    (rd_cnt_o),
    .wr_cnt_o    (wr_cnt_o),
    .abort_cnt_o (abort_cnt_o)
  );

  iomem_ram_ctrl #(.RD_LAT(1), .WR_LAT(1)) dut_f (
    .clk_wiz_o   (clk_wiz_o),
    .rst_n       (rst_n),
    .iomem_valid (valid_f),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .sel_o       (f_sel),
    .ready_o     (f_ready),
    .mem_rd_en_o (f_rd_en),
    .mem_wstrb_o (f_wstrb),
    .busy_o      (f_busy),
    .rd_cnt_o    (f_rd_cnt),
    .wr_cnt_o    (f_wr_cnt),
    .abort_cnt_o (f_abort_cnt)
  );

  // Behavioural RAM: byte lanes written when the controller strobes them
  always @(posedge clk_wiz_o) begin
    if (|mem_wstrb_o) begin
      write_events <= write_events + 1;
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb_o[b]) begin
          ram[iomem_addr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  typedef struct {
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic        exp_sel;
    logic        exp_rd_en;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic next_cycle();
    @(posedge clk_wiz_o);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_wiz_o);
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] s, input logic [31:0] a);
    iomem_valid = v;
    iomem_wstrb = s;
    iomem_addr  = a;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Write with WR_LAT=4: strobes and ready together at accept+4 only
  task automatic do_write(input string tag, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    next_cycle();
    wdata = d;
    applyStimulus(1'b1, s, a);
    for (int k = 0; k <= 4; k++) begin
      if (k != 0) next_cycle();
      sample();
      checkOutput($sformatf("%s_ready_k%0d", tag, k), 32'(ready_o), 32'(k == 4));
      checkOutput($sformatf("%s_wstrb_k%0d", tag, k), 32'(mem_wstrb_o), (k == 4) ? 32'(s) : 32'h0);
      checkOutput($sformatf("%s_rd_en_k%0d", tag, k), 32'(mem_rd_en_o), 32'h0);
    end
    next_cycle();
    applyStimulus(1'b0, 4'h0, 32'h0);
    sample();
    checkOutput({tag, "_ready_after"}, 32'(ready_o), 32'h0);
    checkOutput({tag, "_wstrb_after"}, 32'(mem_wstrb_o), 32'h0);
    checkOutput({tag, "_busy_after"}, 32'(busy_o), 32'h0);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_f = 1'b0;
    wdata   = 32'h0;
    applyStimulus(1'b0, 4'h0, 32'h0);

    vecs[0] = '{1'b1, 4'b0000, 32'h4000_0010, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 4'b0000, 32'h3000_0000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'b1111, 32'h2000_0000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 4'b0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'b0001, 32'h400f_fffc, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'b0000, 32'h4010_0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'b0000, 32'h3000_0004, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'b0000, 32'hc000_0000, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk_wiz_o);
    #1;
    sample();
    checkOutput("rst_ready", 32'(ready_o), 32'h0);
    checkOutput("rst_rd_en", 32'(mem_rd_en_o), 32'h0);
    checkOutput("rst_wstrb", 32'(mem_wstrb_o), 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'h0);
    checkOutput("rst_rd_cnt", 32'(rd_cnt_o), 32'h0);
    checkOutput("rst_wr_cnt", 32'(wr_cnt_o), 32'h0);
    checkOutput("rst_abort_cnt", 32'(abort_cnt_o), 32'h0);
    checkOutput("rst_f_busy", 32'(f_busy), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    sample();

    // Decode table: hits start a transaction that is withdrawn next cycle
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      applyStimulus(vecs[i].valid, vecs[i].wstrb, vecs[i].addr);
      sample();
      checkOutput($sformatf("vec%0d_sel", i), 32'(sel_o), 32'(vecs[i].exp_sel));
      checkOutput($sformatf("vec%0d_rd_en", i), 32'(mem_rd_en_o), 32'(vecs[i].exp_rd_en));
      checkOutput($sformatf("vec%0d_ready", i), 32'(ready_o), 32'h0);
      next_cycle();
      applyStimulus(1'b0, 4'h0, 32'h0);
      sample();
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_ready2", i), 32'(ready_o), 32'h0);
      if (vecs[i].exp_busy) exp_abort++;
      next_cycle();
      sample();
      checkOutput($sformatf("vec%0d_idle", i), 32'(busy_o), 32'h0);
    end
    checkOutput("tbl_abort_cnt", 32'(abort_cnt_o), 32'(exp_abort));
    checkOutput("tbl_rd_cnt", 32'(rd_cnt_o), 32'h0);
    checkOutput("tbl_wr_cnt", 32'(wr_cnt_o), 32'h0);
    checkOutput("tbl_writes", 32'(write_events), 32'h0);

    // Read, RD_LAT=16: ready at accept+16, read enable for 17 cycles
    next_cycle();
    applyStimulus(1'b1, 4'h0, 32'h4000_0010);
    for (int k = 0; k <= 16; k++) begin
      if (k != 0) next_cycle();
      sample();
      checkOutput($sformatf("rd16_ready_k%0d", k), 32'(ready_o), 32'(k == 16));
      checkOutput($sformatf("rd16_rd_en_k%0d", k), 32'(mem_rd_en_o), 32'h1);
    end
    next_cycle();
    applyStimulus(1'b0, 4'h0, 32'h0);
    sample();
    checkOutput("rd16_ready_after", 32'(ready_o), 32'h0);
    checkOutput("rd16_rd_en_after", 32'(mem_rd_en_o), 32'h0);
    checkOutput("rd16_busy_after", 32'(busy_o), 32'h0);
    checkOutput("rd16_rd_cnt", 32'(rd_cnt_o), 32'h1);

    // Write, WR_LAT=4, low half only
    do_write("wr4", 32'h4000_0020, 4'b0011, 32'hdead_beef);
    checkOutput("wr4_wr_cnt", 32'(wr_cnt_o), 32'h1);
    checkOutput("wr4_writes", 32'(write_events), 32'h1);
    checkOutput("wr4_ram", ram[8], 32'h0000_beef);

    // Read withdrawn at accept+5
    next_cycle();
    applyStimulus(1'b1, 4'h0, 32'h4000_0010);
    for (int k = 0; k <= 4; k++) begin
      if (k != 0) next_cycle();
      sample();
      checkOutput($sformatf("abt_ready_k%0d", k), 32'(ready_o), 32'h0);
      checkOutput($sformatf("abt_busy_k%0d", k), 32'(busy_o), 32'(k != 0));
    end
    next_cycle();
    applyStimulus(1'b0, 4'h0, 32'h0);
    sample();
    checkOutput("abt_busy_k5", 32'(busy_o), 32'h1);
    checkOutput("abt_ready_k5", 32'(ready_o), 32'h0);
    next_cycle();
    sample();
    checkOutput("abt_busy_k6", 32'(busy_o), 32'h0);
    checkOutput("abt_ready_k6", 32'(ready_o), 32'h0);
    checkOutput("abt_abort_cnt", 32'(abort_cnt_o), 32'(exp_abort + 1));
    checkOutput("abt_rd_cnt", 32'(rd_cnt_o), 32'h1);

    // Reset during WAIT of a write
    next_cycle();
    wdata = 32'h1234_5678;
    applyStimulus(1'b1, 4'hf, 32'h4000_0030);
    next_cycle();
    sample();
    checkOutput("rstw_busy_k1", 32'(busy_o), 32'h1);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    applyStimulus(1'b0, 4'h0, 32'h0);
    sample();
    checkOutput("rstw_ready", 32'(ready_o), 32'h0);
    checkOutput("rstw_wstrb", 32'(mem_wstrb_o), 32'h0);
    checkOutput("rstw_busy", 32'(busy_o), 32'h0);
    checkOutput("rstw_rd_en", 32'(mem_rd_en_o), 32'h0);
    checkOutput("rstw_rd_cnt", 32'(rd_cnt_o), 32'h0);
    checkOutput("rstw_wr_cnt", 32'(wr_cnt_o), 32'h0);
    checkOutput("rstw_abort_cnt", 32'(abort_cnt_o), 32'h0);
    next_cycle();
    rst_n = 1'b1;
    sample();
    checkOutput("rstw_writes", 32'(write_events), 32'h1);
    checkOutput("rstw_ram", ram[12], 32'h0);

    // Normal write after reset
    do_write("wrpost", 32'h4000_0030, 4'b1100, 32'hcafe_f00d);
    checkOutput("wrpost_wr_cnt", 32'(wr_cnt_o), 32'h1);
    checkOutput("wrpost_writes", 32'(write_events), 32'h2);
    checkOutput("wrpost_ram", ram[12], 32'hcafe_0000);

    // Back-to-back reads on the RD_LAT=1 instance
    next_cycle();
    applyStimulus(1'b0, 4'h0, 32'h4000_0040);
    valid_f = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k != 0) next_cycle();
      sample();
      checkOutput($sformatf("b2b_ready_k%0d", k), 32'(f_ready), 32'(k % 2 == 1));
      checkOutput($sformatf("b2b_rd_en_k%0d", k), 32'(f_rd_en), 32'h1);
    end
    next_cycle();
    valid_f = 1'b0;
    sample();
    checkOutput("b2b_ready_after", 32'(f_ready), 32'h0);
    checkOutput("b2b_busy_after", 32'(f_busy), 32'h0);
    checkOutput("b2b_rd_en_after", 32'(f_rd_en), 32'h0);
    checkOutput("b2b_rd_cnt", 32'(f_rd_cnt), 32'h3);
    checkOutput("b2b_main_busy", 32'(busy_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
